// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive frame controller:
//   - binary-encoded frame state constants
//   - check-edge offset inside a bit period
//   - legal oversampling ratios and a helper that folds any other ratio to x8
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  // Frame states, binary encoded
  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE   = 3'd0;
  localparam rx_state_t ST_START  = 3'd1;
  localparam rx_state_t ST_DATA   = 3'd2;
  localparam rx_state_t ST_PARITY = 3'd3;
  localparam rx_state_t ST_STOP   = 3'd4;
  localparam rx_state_t ST_DONE   = 3'd5;

  // The check edge sits this many oversampling edges past mid-bit
  localparam int CHK_OFFSET = 2;

  // Legal oversampling ratios
  localparam logic [31:0] PRESCALE_X8  = 32'd8;
  localparam logic [31:0] PRESCALE_X16 = 32'd16;
  localparam logic [31:0] PRESCALE_X32 = 32'd32;

  // Map a requested ratio onto a legal one; anything unsupported runs at x8
  function automatic logic [31:0] legal_prescale(input logic [31:0] req);
    case (req)
      PRESCALE_X8,
      PRESCALE_X16,
      PRESCALE_X32: legal_prescale = req;
      default:      legal_prescale = PRESCALE_X8;
    endcase
  endfunction

  // States in which a bit period is being timed on the line
  function automatic logic is_bit_state(input rx_state_t st);
    case (st)
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP: is_bit_state = 1'b1;
      default: is_bit_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// -----------------------------------------------------------------------------
// uart_rx_edge_bit_cnt
// Oversampling edge counter and data-bit counter for the UART receiver.
//
// Ports
//   CLK, RST     : RX oversampling clock, async active-low reset
//   clear_i      : hold both counters at 0 (frame controller idle / done)
//   bit_adv_i    : advance the data-bit index by one
//   p_i          : frame-latched oversampling ratio P
//   edge_cnt_o   : edge index within the current bit, 0 .. P-1
//   bit_cnt_o    : data bit index
//   chk_o        : edge_cnt is one below the check edge (P/2 + CHK_OFFSET)
//   end_o        : edge_cnt is at the bit-end edge (P-1)
//
// chk_o leads the check edge by one cycle so that the controller can
// register its enable pulses and still have them line up with
// edge_cnt == check edge.
// -----------------------------------------------------------------------------
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_W      = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clear_i,
  input  logic                  bit_adv_i,
  input  logic [PRESCALE_W-1:0] p_i,
  output logic [PRESCALE_W-1:0] edge_cnt_o,
  output logic [BIT_W-1:0]      bit_cnt_o,
  output logic                  chk_o,
  output logic                  end_o
);

  logic [PRESCALE_W-1:0] edge_q;
  logic [PRESCALE_W-1:0] edge_d;
  logic [BIT_W-1:0]      bit_q;
  logic [BIT_W-1:0]      bit_d;
  logic [PRESCALE_W-1:0] end_val_s;
  logic [PRESCALE_W-1:0] chk_pre_s;

  assign end_val_s = p_i - PRESCALE_W'(1);
  assign chk_pre_s = (p_i >> 1) + PRESCALE_W'(CHK_OFFSET - 1);

  assign end_o      = (edge_q == end_val_s);
  assign chk_o      = (edge_q == chk_pre_s);
  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;

  // Next edge index: wraps at the bit-end edge, held at 0 while cleared
  always_comb begin
    edge_d = edge_q;
    if (clear_i) begin
      edge_d = '0;
    end else if (end_o) begin
      edge_d = '0;
    end else begin
      edge_d = edge_q + PRESCALE_W'(1);
    end
  end

  // Next data-bit index
  always_comb begin
    bit_d = bit_q;
    if (clear_i) begin
      bit_d = '0;
    end else if (bit_adv_i) begin
      bit_d = bit_q + BIT_W'(1);
    end else begin
      bit_d = bit_q;
    end
  end

  // Counter registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm
// Frame-level controller for the UART receiver. Detects the start-bit falling
// edge, times every bit with the oversampling edge counter, pulses the check /
// shift enables of the RX datapath units, and closes the frame with
// Flags_Done and a qualified Data_Valid.
//
// Ports
//   CLK, RST        : RX oversampling clock, async active-low reset
//   RX_IN           : synchronized serial line, idle high
//   Prescale        : requested oversampling ratio (8/16/32, else x8)
//   PAR_EN          : frame carries a parity bit
//   Strt_glitch     : start-check error from the start-check unit
//   Par_err         : parity error from the parity-check unit
//   Stp_err         : stop-bit error from the stop-check unit
//   dat_samp_en     : data-sampling enable, high through START..STOP
//   strt_chk_en     : start-check enable pulse
//   deser_en        : deserializer shift pulse
//   par_chk_en      : parity-check enable pulse
//   stp_chk_en      : stop-check enable pulse
//   Flags_Done      : end-of-frame pulse, clears the check flags
//   Data_Valid      : received byte is good, pulse
//   edge_cnt        : edge index within the current bit
//   bit_cnt         : data bit index
//
// All control outputs are registered and decoded from the next state and the
// counter lookahead, so every pulse coincides with edge_cnt at the check edge.
// -----------------------------------------------------------------------------
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          RX_IN,
  input  logic [PRESCALE_W-1:0]         Prescale,
  input  logic                          PAR_EN,
  input  logic                          Strt_glitch,
  input  logic                          Par_err,
  input  logic                          Stp_err,
  output logic                          dat_samp_en,
  output logic                          strt_chk_en,
  output logic                          deser_en,
  output logic                          par_chk_en,
  output logic                          stp_chk_en,
  output logic                          Flags_Done,
  output logic                          Data_Valid,
  output logic [PRESCALE_W-1:0]         edge_cnt,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_cnt
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  rx_state_t             state_q;
  rx_state_t             state_d;
  logic [PRESCALE_W-1:0] p_q;
  logic [PRESCALE_W-1:0] p_d;
  logic                  par_en_q;
  logic                  par_en_d;

  logic                  dat_samp_en_q, dat_samp_en_d;
  logic                  strt_chk_en_q, strt_chk_en_d;
  logic                  deser_en_q,    deser_en_d;
  logic                  par_chk_en_q,  par_chk_en_d;
  logic                  stp_chk_en_q,  stp_chk_en_d;
  logic                  flags_done_q,  flags_done_d;
  logic                  data_valid_q,  data_valid_d;

  logic [PRESCALE_W-1:0] edge_cnt_s;
  logic [BIT_W-1:0]      bit_cnt_s;
  logic                  chk_s;
  logic                  end_s;
  logic                  clear_s;
  logic                  bit_adv_s;
  logic                  last_bit_s;
  logic [PRESCALE_W-1:0] p_legal_s;

  assign p_legal_s  = PRESCALE_W'(legal_prescale(32'(Prescale)));
  assign last_bit_s = (bit_cnt_s == LAST_BIT);
  // Counters sit at 0 outside bit states so the first cycle of START is edge 0
  assign clear_s    = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign bit_adv_s  = (state_q == ST_DATA) && end_s && !last_bit_s;

  uart_rx_edge_bit_cnt #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_W      (BIT_W)
  ) u_cnt (
    .CLK        (CLK),
    .RST        (RST),
    .clear_i    (clear_s),
    .bit_adv_i  (bit_adv_s),
    .p_i        (p_q),
    .edge_cnt_o (edge_cnt_s),
    .bit_cnt_o  (bit_cnt_s),
    .chk_o      (chk_s),
    .end_o      (end_s)
  );

  // Next state, prescale latch and parity-mode latch
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    par_en_d = par_en_q;
    case (state_q)
      ST_IDLE: begin
        if (!RX_IN) begin
          state_d = ST_START;
          p_d     = p_legal_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (end_s) begin
          state_d = Strt_glitch ? ST_IDLE : ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (end_s && last_bit_s) begin
          par_en_d = PAR_EN;
          state_d  = PAR_EN ? ST_PARITY : ST_STOP;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (end_s) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (end_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_DONE: begin
        // A low line here is the next frame's start bit: skip IDLE
        if (!RX_IN) begin
          state_d = ST_START;
          p_d     = p_legal_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode, one cycle ahead of the output registers
  always_comb begin
    dat_samp_en_d = is_bit_state(state_d);
    // chk_s looks one edge ahead and never coincides with a state change
    strt_chk_en_d = (state_q == ST_START)  && chk_s;
    deser_en_d    = (state_q == ST_DATA)   && chk_s;
    par_chk_en_d  = (state_q == ST_PARITY) && chk_s;
    stp_chk_en_d  = (state_q == ST_STOP)   && chk_s;
    flags_done_d  = (state_d == ST_DONE);
    // Parity error only counts for frames that carried a parity bit
    data_valid_d  = (state_d == ST_DONE) && !Stp_err && !(par_en_q && Par_err);
  end

  // State and frame-latch registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      p_q      <= '0;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      par_en_q <= par_en_d;
    end
  end

  // Registered control outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dat_samp_en_q <= 1'b0;
      strt_chk_en_q <= 1'b0;
      deser_en_q    <= 1'b0;
      par_chk_en_q  <= 1'b0;
      stp_chk_en_q  <= 1'b0;
      flags_done_q  <= 1'b0;
      data_valid_q  <= 1'b0;
    end else begin
      dat_samp_en_q <= dat_samp_en_d;
      strt_chk_en_q <= strt_chk_en_d;
      deser_en_q    <= deser_en_d;
      par_chk_en_q  <= par_chk_en_d;
      stp_chk_en_q  <= stp_chk_en_d;
      flags_done_q  <= flags_done_d;
      data_valid_q  <= data_valid_d;
    end
  end

  assign dat_samp_en = dat_samp_en_q;
  assign strt_chk_en = strt_chk_en_q;
  assign deser_en    = deser_en_q;
  assign par_chk_en  = par_chk_en_q;
  assign stp_chk_en  = stp_chk_en_q;
  assign Flags_Done  = flags_done_q;
  assign Data_Valid  = data_valid_q;
  assign edge_cnt    = edge_cnt_s;
  assign bit_cnt     = bit_cnt_s;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fsm
// Directed bench for the UART receive frame controller. The bench plays both
// the serial line and the check units (it drives the error flags itself).
// Inputs change and outputs are observed on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       Strt_glitch = 1'b0;
  logic       Par_err = 1'b0;
  logic       Stp_err = 1'b0;
  logic       dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en;
  logic       Flags_Done, Data_Valid;
  logic [5:0] edge_cnt;
  logic [2:0] bit_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-frame observations filled in by drive_frame
  int         fr_done;
  logic       fr_dv;
  int         fr_deser, fr_deser_bad, fr_par, fr_strt, fr_stp;
  int         fr_samp_bad, fr_dv_stray;
  logic [5:0] fr_edge0;

  uart_rx_fsm #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .Strt_glitch (Strt_glitch),
    .Par_err     (Par_err),
    .Stp_err     (Stp_err),
    .dat_samp_en (dat_samp_en),
    .strt_chk_en (strt_chk_en),
    .deser_en    (deser_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .Flags_Done  (Flags_Done),
    .Data_Valid  (Data_Valid),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt)
  );

  always #5 CLK = ~CLK;

  // Drive one frame starting at the current falling edge. Cycle 0 is the first
  // START cycle. Returns at the falling edge of the Flags_Done cycle, leaving
  // RX_IN at 'tail' (0 starts a back-to-back frame).
  task automatic drive_frame(input logic [7:0] data, input logic [5:0] presc_in,
                             input int p, input logic par, input logic stop_bit,
                             input logic tail);
    logic [11:0] bits;
    int          nbits;
    int          idx;
    bits    = 12'hFFF;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    if (par) begin
      bits[9]  = ^data;
      bits[10] = stop_bit;
      nbits    = 11;
    end else begin
      bits[9]  = stop_bit;
      nbits    = 10;
    end
    fr_done = -1; fr_dv = 1'b0; fr_deser = 0; fr_deser_bad = 0; fr_par = 0;
    fr_strt = 0; fr_stp = 0; fr_samp_bad = 0; fr_dv_stray = 0; fr_edge0 = 6'h3F;
    Prescale = presc_in;
    PAR_EN   = par;
    RX_IN    = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge CLK);
      if (c == 0) fr_edge0 = edge_cnt;
      // Scramble the ratio mid-frame; the latched value must be kept
      if (c == 1) Prescale = (p == 32) ? 6'd8 : 6'd32;
      if (deser_en) begin
        fr_deser++;
        if (edge_cnt != 6'(p / 2 + 2)) fr_deser_bad++;
      end
      if (par_chk_en)  fr_par++;
      if (strt_chk_en) fr_strt++;
      if (stp_chk_en)  fr_stp++;
      if (Data_Valid && !Flags_Done) fr_dv_stray++;
      if (Flags_Done) begin
        fr_done = c;
        fr_dv   = Data_Valid;
        if (dat_samp_en) fr_samp_bad++;
        RX_IN = tail;
        break;
      end
      if (!dat_samp_en) fr_samp_bad++;
      idx   = (c + 1) / p;
      RX_IN = (idx < nbits) ? bits[idx] : tail;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, Flags_Done,
         Data_Valid, edge_cnt, bit_cnt} !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got samp=%b done=%b dv=%b edge=%0d bit=%0d want all 0",
               dat_samp_en, Flags_Done, Data_Valid, edge_cnt, bit_cnt);
    end
    RST = 1'b1;
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({dat_samp_en, Flags_Done, edge_cnt} !== 8'h0) begin
      n_bad++;
      $display("FAIL reset_idle: got samp=%b done=%b edge=%0d want 0/0/0",
               dat_samp_en, Flags_Done, edge_cnt);
    end
  endtask

  task automatic test_clean_frame();
    Par_err = 1'b0; Stp_err = 1'b0;
    drive_frame(8'hA5, 6'd8, 8, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (fr_done !== 88) begin n_bad++; $display("FAIL clean_done_cycle: got %0d want 88", fr_done); end
    n_cmp++; if (fr_dv !== 1'b1) begin n_bad++; $display("FAIL clean_valid: got %b want 1", fr_dv); end
    n_cmp++; if (fr_deser !== 8) begin n_bad++; $display("FAIL clean_deser_count: got %0d want 8", fr_deser); end
    n_cmp++; if (fr_deser_bad !== 0) begin n_bad++; $display("FAIL clean_deser_edge: got %0d off-edge want 0", fr_deser_bad); end
    n_cmp++; if (fr_par !== 1) begin n_bad++; $display("FAIL clean_par_count: got %0d want 1", fr_par); end
    n_cmp++; if (fr_strt !== 1) begin n_bad++; $display("FAIL clean_strt_count: got %0d want 1", fr_strt); end
    n_cmp++; if (fr_stp !== 1) begin n_bad++; $display("FAIL clean_stp_count: got %0d want 1", fr_stp); end
    n_cmp++; if (fr_samp_bad !== 0) begin n_bad++; $display("FAIL clean_samp_en: got %0d bad cycles want 0", fr_samp_bad); end
    n_cmp++; if (fr_edge0 !== 6'd0) begin n_bad++; $display("FAIL clean_edge0: got %0d want 0", fr_edge0); end
    n_cmp++; if (fr_dv_stray !== 0) begin n_bad++; $display("FAIL clean_dv_stray: got %0d want 0", fr_dv_stray); end
    @(negedge CLK);
    n_cmp++;
    if ({dat_samp_en, Flags_Done, Data_Valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL clean_after_done: got samp=%b done=%b dv=%b want 000",
               dat_samp_en, Flags_Done, Data_Valid);
    end
  endtask

  task automatic test_no_parity();
    Par_err = 1'b1;  // must be ignored without a parity bit
    drive_frame(8'h3C, 6'd16, 16, 1'b0, 1'b1, 1'b1);
    Par_err = 1'b0;
    n_cmp++; if (fr_done !== 160) begin n_bad++; $display("FAIL nopar_done_cycle: got %0d want 160", fr_done); end
    n_cmp++; if (fr_par !== 0) begin n_bad++; $display("FAIL nopar_par_count: got %0d want 0", fr_par); end
    n_cmp++; if (fr_dv !== 1'b1) begin n_bad++; $display("FAIL nopar_valid: got %b want 1", fr_dv); end
    n_cmp++; if (fr_deser_bad !== 0 || fr_deser !== 8) begin n_bad++; $display("FAIL nopar_deser: got %0d pulses %0d off-edge want 8/0", fr_deser, fr_deser_bad); end
    @(negedge CLK);
  endtask

  task automatic test_illegal_prescale();
    drive_frame(8'h81, 6'd12, 8, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (fr_done !== 80) begin n_bad++; $display("FAIL illegal_ps_done_cycle: got %0d want 80", fr_done); end
    n_cmp++; if (fr_deser_bad !== 0) begin n_bad++; $display("FAIL illegal_ps_deser_edge: got %0d off-edge want 0", fr_deser_bad); end
    @(negedge CLK);
  endtask

  task automatic test_start_glitch();
    int n_fd;
    int n_strt;
    logic s7, s8;
    n_fd = 0; n_strt = 0; s7 = 1'b0; s8 = 1'b1;
    Strt_glitch = 1'b1;
    Prescale = 6'd8;
    RX_IN = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      if (c == 2) RX_IN = 1'b1;
      if (Flags_Done || Data_Valid) n_fd++;
      if (strt_chk_en) n_strt++;
      if (c == 7) s7 = dat_samp_en;
      if (c == 8) s8 = dat_samp_en;
    end
    Strt_glitch = 1'b0;
    n_cmp++; if (n_fd !== 0) begin n_bad++; $display("FAIL glitch_no_done: got %0d pulses want 0", n_fd); end
    n_cmp++; if (n_strt !== 1) begin n_bad++; $display("FAIL glitch_strt_count: got %0d want 1", n_strt); end
    n_cmp++; if (s7 !== 1'b1) begin n_bad++; $display("FAIL glitch_last_start: got samp=%b want 1", s7); end
    n_cmp++; if (s8 !== 1'b0) begin n_bad++; $display("FAIL glitch_back_idle: got samp=%b want 0", s8); end
  endtask

  task automatic test_stop_error();
    Stp_err = 1'b1;
    drive_frame(8'h96, 6'd8, 8, 1'b1, 1'b0, 1'b1);
    Stp_err = 1'b0;
    n_cmp++; if (fr_done !== 88) begin n_bad++; $display("FAIL stperr_done_cycle: got %0d want 88", fr_done); end
    n_cmp++; if (fr_dv !== 1'b0) begin n_bad++; $display("FAIL stperr_valid: got %b want 0", fr_dv); end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    drive_frame(8'hA5, 6'd8, 8, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (fr_done !== 88 || fr_dv !== 1'b1) begin n_bad++; $display("FAIL b2b_first: got done=%0d dv=%b want 88/1", fr_done, fr_dv); end
    drive_frame(8'h5A, 6'd16, 16, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (fr_done !== 160) begin n_bad++; $display("FAIL b2b_second_done: got %0d want 160", fr_done); end
    n_cmp++; if (fr_dv !== 1'b1) begin n_bad++; $display("FAIL b2b_second_valid: got %b want 1", fr_dv); end
    n_cmp++; if (fr_samp_bad !== 0 || fr_edge0 !== 6'd0) begin n_bad++; $display("FAIL b2b_no_idle: got %0d bad samp, edge0=%0d want 0/0", fr_samp_bad, fr_edge0); end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_data();
    int hit;
    hit = -1;
    Prescale = 6'd8;
    PAR_EN = 1'b1;
    RX_IN = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      if (c == 7) RX_IN = 1'b1;
      if (bit_cnt == 3'd4 && dat_samp_en) begin
        hit = c;
        break;
      end
    end
    n_cmp++; if (hit !== 40) begin n_bad++; $display("FAIL rstmid_bit4_cycle: got %0d want 40", hit); end
    RST = 1'b0;
    #1;
    n_cmp++;
    if ({dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, Flags_Done,
         Data_Valid, edge_cnt, bit_cnt} !== 16'h0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got samp=%b done=%b dv=%b edge=%0d bit=%0d want all 0",
               dat_samp_en, Flags_Done, Data_Valid, edge_cnt, bit_cnt);
    end
    @(negedge CLK);
    RX_IN = 1'b1;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++; if ({dat_samp_en, Flags_Done} !== 2'b00) begin n_bad++; $display("FAIL rstmid_idle: got samp=%b done=%b want 00", dat_samp_en, Flags_Done); end
    drive_frame(8'hC3, 6'd8, 8, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (fr_done !== 88 || fr_dv !== 1'b1) begin n_bad++; $display("FAIL rstmid_next_frame: got done=%0d dv=%b want 88/1", fr_done, fr_dv); end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_no_parity();
    test_illegal_prescale();
    test_start_glitch();
    test_stop_error();
    test_back_to_back();
    test_reset_mid_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Frame-level controller for the UART receiver. It detects the start-bit falling edge and runs the oversampling edge counter and bit counter. It sequences the enables of the data-sampling, start-check, deserializer, parity-check and stop-check units, then qualifies the received byte with `Data_Valid` and pulses `Flags_Done` to clear the check flags. It sits in the RX clock domain between the `RX_IN` pad synchronizer and the RX datapath units.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `PRESCALE_W`, default 6: width of the `Prescale` and `edge_cnt` fields.
- `CLK`  in  1  RX oversampling clock, Prescale × bit rate.
- `RST`  in  1  reset, asynchronous, active-low.
- `RX_IN`  in  1  synchronized serial line, idle high.
- `Prescale`  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
- `PAR_EN`  in  1  parity bit present in frame.
- `Strt_glitch`  in  1  registered start-check error.
- `Par_err`  in  1  registered parity error.
- `Stp_err`  in  1  registered stop-bit error.
- `dat_samp_en`  out  1  data-sampling unit enable.
- `strt_chk_en`  out  1  start-check enable, 1-cycle pulse.
- `deser_en`  out  1  deserializer shift enable, 1-cycle pulse.
- `par_chk_en`  out  1  parity-check enable, 1-cycle pulse.
- `stp_chk_en`  out  1  stop-check enable, 1-cycle pulse.
- `Flags_Done`  out  1  frame end, clears the check flags; 1-cycle pulse.
- `Data_Valid`  out  1  deserialized byte valid; 1-cycle pulse.
- `edge_cnt`  out  PRESCALE_W  oversampling edge index within the current bit.
- `bit_cnt`  out  $clog2(DATA_WIDTH)  data bit index.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- `P` is the frame-latched prescale. `CHK` = P/2+2 is the check edge. `END` = P−1 is the bit-end edge.
- **IDLE**
  - Counters are held at 0.
  - `RX_IN`=0 → START.
  - `Prescale` is latched into `P` on this transition and held for the whole frame.
- **START**
  - `strt_chk_en` pulses at `edge_cnt`==CHK.
  - At END: `Strt_glitch`=1 → IDLE; otherwise → DATA with `bit_cnt`=0.
- **DATA**
  - `deser_en` pulses at CHK.
  - At END: if `bit_cnt`==DATA_WIDTH−1 → PARITY when `PAR_EN`=1, else STOP.
  - Otherwise `bit_cnt` increments.
- **PARITY**: `par_chk_en` pulses at CHK; at END → STOP.
- **STOP**: `stp_chk_en` pulses at CHK; at END → DONE.
- **DONE** (exactly one cycle)
  - `Flags_Done`=1.
  - `Data_Valid` = ~`Par_err` & ~`Stp_err`. `Par_err` is ignored when `PAR_EN`=0.
  - Next state: `RX_IN`=0 → START (back-to-back frame, `P` re-latched); otherwise → IDLE.
- `dat_samp_en`=1 in START, DATA, PARITY and STOP; 0 in IDLE and DONE.
- `edge_cnt` is 0 on the first cycle of every bit state and wraps END→0 at each bit boundary.
- `PAR_EN` is sampled at the DATA→next transition only.

## Timing
- Reset: state IDLE; `edge_cnt`, `bit_cnt` and `P` at 0; every output 0.
- Asserting reset mid-frame aborts immediately to IDLE with no `Flags_Done` and no `Data_Valid`.
- Enable pulses are registered Moore outputs decoded from state and `edge_cnt`.
- Each check flag is registered by its check unit one cycle after the enable pulse. The flags are therefore stable well before DONE.
- Frame length from the first START cycle to DONE:
  - P×(DATA_WIDTH+3) cycles with parity.
  - P×(DATA_WIDTH+2) cycles without parity.
- Any `Prescale` change during a frame has no effect until the next IDLE/DONE→START transition.
- An illegal `Prescale` value (not 8, 16 or 32) is latched as 8.

## Structure
- Package `uart_rx_pkg`:
  - state enum with binary encoding;
  - `CHK_OFFSET`=2;
  - legal prescale constants.
- Sub-module `uart_rx_edge_bit_cnt`:
  - inputs: clear, bit-advance and `P`;
  - outputs: `edge_cnt`, `bit_cnt` and the `chk`/`end` strobes.
- The FSM owns the state register, the latch of `P`, and output decode.

## Test plan
- **Clean frame:** Prescale=8, PAR_EN=1 (even parity), data 0xA5, stop=1 → `Data_Valid` pulses 88 cycles after the first START cycle; `deser_en` fires 8 times, at `edge_cnt`=6 each time.
- **No parity:** Prescale=16, PAR_EN=0, data 0x3C → `par_chk_en` never fires; DONE is reached after 160 cycles; `Data_Valid`=1.
- **Start glitch:** `RX_IN` low for 3 cycles at Prescale=8, bench drives `Strt_glitch`=1 → return to IDLE at the end of START; no `Flags_Done`.
- **Stop error:** stop bit driven 0, bench drives `Stp_err`=1 → `Flags_Done`=1 with `Data_Valid`=0 in DONE.
- **Back-to-back frames:** `RX_IN`=0 during DONE → direct DONE→START with no IDLE cycle; second byte 0x5A is valid.
- **Reset mid-DATA:** RST low at `bit_cnt`=4 → all outputs 0; the next frame is received cleanly.
